// File: rtl/axi_master_txn_arbiter.sv
// axi_master_txn_arbiter: round-robin sharing of the AXI master command interface with per-channel response routing and timeout
module axi_master_txn_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                            AClk,
    input  logic                            ARst,
    input  logic [NUM_REQ-1:0]              wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NUM_REQ*8-1:0]            wr_len,
    input  logic [NUM_REQ*3-1:0]            wr_size,
    input  logic [NUM_REQ*2-1:0]            wr_burst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_REQ*8-1:0]            wr_strb,
    output logic [NUM_REQ-1:0]              wr_gnt,
    output logic [NUM_REQ-1:0]              wr_done,
    output logic [1:0]                      wr_resp,
    input  logic [NUM_REQ-1:0]              rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rd_addr,
    input  logic [NUM_REQ*8-1:0]            rd_len,
    input  logic [NUM_REQ*3-1:0]            rd_size,
    input  logic [NUM_REQ*2-1:0]            rd_burst,
    output logic [NUM_REQ-1:0]              rd_gnt,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [1:0]                      rd_resp,
    output logic                            rd_last,
    output logic [3:0]                      TXN_ID_W_d,
    output logic [ADDR_WIDTH-1:0]           awaddr_d,
    output logic [7:0]                      awlen_d,
    output logic [2:0]                      awsize_d,
    output logic [1:0]                      awburst_d,
    output logic                            awlock_d,
    output logic [3:0]                      awcache_d,
    output logic [2:0]                      awprot_d,
    output logic [DATA_WIDTH-1:0]           wdata_d,
    output logic [7:0]                      wstrb_d,
    output logic                            wr_trn_en,
    input  logic [1:0]                      bresp_d,
    input  logic [3:0]                      bid_d,
    input  logic                            wr_rsp_en_d,
    output logic [7:0]                      TXN_ID_R_d,
    output logic [ADDR_WIDTH-1:0]           araddr_d,
    output logic [7:0]                      arlen_d,
    output logic [2:0]                      arsize_d,
    output logic [1:0]                      arburst_d,
    output logic                            arlock_d,
    output logic [3:0]                      arcache_d,
    output logic [2:0]                      arprot_d,
    output logic                            rd_trn_en,
    input  logic [DATA_WIDTH-1:0]           rdata_d,
    input  logic [1:0]                      rresp_d,
    input  logic [7:0]                      rid_d,
    input  logic                            rd_rsp_en_d,
    input  logic                            r_last_d,
    output logic                            err_timeout,
    output logic                            err_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0] NR = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [1:0] W_IDLE = 2'd0, W_ISSUE = 2'd1, W_WAIT = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_ISSUE = 2'd1, R_DATA = 2'd2;

    logic [1:0]    wr_state, rd_state;
    logic [IW-1:0] wr_ptr, rd_ptr, wr_pick, rd_pick;
    logic [31:0]   wr_timer, rd_timer;
    logic          wr_err_id, rd_err_id, wr_err_to, rd_err_to;

    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] s;
        rr_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (IW + 1)'(k);
            s = s >= NR ? s - NR : s;
            if (req[s[IW-1:0]]) rr_pick = s[IW-1:0];
        end
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        next_ptr = p == LAST_IDX ? '0 : p + 1'b1;
    endfunction

    assign wr_pick     = rr_pick(wr_req, wr_ptr);
    assign rd_pick     = rr_pick(rd_req, rd_ptr);
    assign wr_trn_en   = wr_state == W_ISSUE;
    assign rd_trn_en   = rd_state == R_ISSUE;
    assign wdata_d     = |wr_gnt ? wr_data[int'(TXN_ID_W_d)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wstrb_d     = |wr_gnt ? wr_strb[int'(TXN_ID_W_d)*8 +: 8] : '0;
    assign awlock_d    = 1'b0;
    assign awcache_d   = '0;
    assign awprot_d    = '0;
    assign arlock_d    = 1'b0;
    assign arcache_d   = '0;
    assign arprot_d    = '0;
    assign err_timeout = wr_err_to | rd_err_to;
    assign err_id      = wr_err_id | rd_err_id;

    always_ff @(posedge AClk) begin
        if (ARst) begin
            wr_state   <= W_IDLE;
            wr_ptr     <= '0;
            wr_timer   <= '0;
            wr_gnt     <= '0;
            wr_done    <= '0;
            wr_resp    <= '0;
            TXN_ID_W_d <= '0;
            awaddr_d   <= '0;
            awlen_d    <= '0;
            awsize_d   <= '0;
            awburst_d  <= '0;
            wr_err_id  <= 1'b0;
            wr_err_to  <= 1'b0;
        end else begin
            wr_done <= '0;
            if (wr_rsp_en_d && wr_state != W_WAIT) wr_err_id <= 1'b1;
            if (wr_state == W_IDLE) begin
                if (|wr_req && ~|wr_done) begin
                    wr_gnt     <= NUM_REQ'(1) << wr_pick;
                    awaddr_d   <= wr_addr[int'(wr_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    awlen_d    <= wr_len[int'(wr_pick)*8 +: 8];
                    awsize_d   <= wr_size[int'(wr_pick)*3 +: 3];
                    awburst_d  <= wr_burst[int'(wr_pick)*2 +: 2];
                    TXN_ID_W_d <= 4'(wr_pick);
                    wr_ptr     <= next_ptr(wr_pick);
                    wr_state   <= W_ISSUE;
                end
            end else if (wr_state == W_ISSUE) begin
                wr_timer <= '0;
                wr_state <= W_WAIT;
            end else if (wr_rsp_en_d) begin
                wr_done  <= wr_gnt;
                wr_resp  <= bid_d != TXN_ID_W_d ? 2'b10 : bresp_d;
                if (bid_d != TXN_ID_W_d) wr_err_id <= 1'b1;
                wr_gnt   <= '0;
                wr_state <= W_IDLE;
            end else if (wr_timer >= TO_LAST) begin
                wr_done   <= wr_gnt;
                wr_resp   <= 2'b10;
                wr_err_to <= 1'b1;
                wr_gnt    <= '0;
                wr_state  <= W_IDLE;
            end else begin
                wr_timer <= wr_timer + {31'd0, wr_timer != '1};
            end
        end
    end

    always_ff @(posedge AClk) begin
        if (ARst) begin
            rd_state   <= R_IDLE;
            rd_ptr     <= '0;
            rd_timer   <= '0;
            rd_gnt     <= '0;
            rd_valid   <= '0;
            rd_data    <= '0;
            rd_resp    <= '0;
            rd_last    <= 1'b0;
            TXN_ID_R_d <= '0;
            araddr_d   <= '0;
            arlen_d    <= '0;
            arsize_d   <= '0;
            arburst_d  <= '0;
            rd_err_id  <= 1'b0;
            rd_err_to  <= 1'b0;
        end else begin
            rd_valid <= '0;
            rd_last  <= 1'b0;
            if (rd_rsp_en_d && rd_state != R_DATA) rd_err_id <= 1'b1;
            if (rd_state == R_IDLE) begin
                if (|rd_req && ~|rd_valid) begin
                    rd_gnt     <= NUM_REQ'(1) << rd_pick;
                    araddr_d   <= rd_addr[int'(rd_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    arlen_d    <= rd_len[int'(rd_pick)*8 +: 8];
                    arsize_d   <= rd_size[int'(rd_pick)*3 +: 3];
                    arburst_d  <= rd_burst[int'(rd_pick)*2 +: 2];
                    TXN_ID_R_d <= 8'(rd_pick);
                    rd_ptr     <= next_ptr(rd_pick);
                    rd_state   <= R_ISSUE;
                end
            end else if (rd_state == R_ISSUE) begin
                rd_timer <= '0;
                rd_state <= R_DATA;
            end else if (rd_rsp_en_d) begin
                rd_valid <= rd_gnt;
                rd_data  <= rdata_d;
                rd_resp  <= rresp_d;
                rd_last  <= r_last_d;
                rd_timer <= '0;
                if (rid_d != TXN_ID_R_d) rd_err_id <= 1'b1;
                if (r_last_d) begin
                    rd_gnt   <= '0;
                    rd_state <= R_IDLE;
                end
            end else if (rd_timer >= TO_LAST) begin
                rd_valid  <= rd_gnt;
                rd_resp   <= 2'b10;
                rd_last   <= 1'b1;
                rd_err_to <= 1'b1;
                rd_gnt    <= '0;
                rd_state  <= R_IDLE;
            end else begin
                rd_timer <= rd_timer + {31'd0, rd_timer != '1};
            end
        end
    end
endmodule
